// File: rtl/imm_operand_encoder_pkg.sv
// Shared widths, candidate forms and FSM encoding for the immediate operand encoder.
// Form codes match the `form` output seen by the loader and self-test sequencer.
package imm_operand_encoder_pkg;

    localparam int WORD            = 32;
    localparam int SHIFTER_OPERAND = 12;

    localparam logic [1:0] IMM_FORM_DIRECT = 2'b00;
    localparam logic [1:0] IMM_FORM_INV    = 2'b01;
    localparam logic [1:0] IMM_FORM_NEG    = 2'b10;

    // 16 rotations for each of the three forms
    localparam int IMM_CANDIDATES = 48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/imm_fit_check.sv
// Tests one candidate: rotating c left by 2*rot must leave only the low byte set,
// which is the inverse of the operand decoder's ror(imm8, 2*rot).
module imm_fit_check
    import imm_operand_encoder_pkg::*;
(
    input  logic [WORD-1:0] c,
    input  logic [3:0]      rot,
    output logic            fits,
    output logic [7:0]      imm8
);

    logic [2*WORD-1:0] dbl;
    logic [WORD-1:0]   t;

    // Upper half of {c,c} shifted left is rol(c, 2*rot)
    assign dbl  = {c, c} << {rot, 1'b0};
    assign t    = dbl[2*WORD-1:WORD];
    assign fits = (t[WORD-1:8] == '0);
    assign imm8 = t[7:0];

endmodule

// File: rtl/imm_operand_encoder.sv
// Multi-cycle search for an ARM rotated-immediate encoding of a 32-bit constant,
// trying direct, inverted and negated forms, one candidate per cycle.
module imm_operand_encoder
    import imm_operand_encoder_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WORD-1:0]            value,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [1:0]                 form,
    output logic [SHIFTER_OPERAND-1:0] shift_op
);

    state_e          state_q, state_d;
    logic [5:0]      k_q;
    logic [WORD-1:0] value_q;
    logic [WORD-1:0] cand;
    logic            fits;
    logic [7:0]      imm8;
    logic            accept;
    logic            last;

    assign accept = start && (state_q != ST_SEARCH);
    assign last   = (k_q == 6'(IMM_CANDIDATES - 1));

    // k[5:4] selects the form, k[3:0] is the rotation
    always_comb begin
        cand = '0;
        case (k_q[5:4])
            IMM_FORM_DIRECT: cand = value_q;
            IMM_FORM_INV:    cand = ~value_q;
            IMM_FORM_NEG:    cand = -value_q;
            default:         cand = '0;
        endcase
    end

    imm_fit_check u_fit (
        .c    (cand),
        .rot  (k_q[3:0]),
        .fits (fits),
        .imm8 (imm8)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SEARCH;
            ST_SEARCH: if (fits || last) state_d = ST_DONE;
            ST_DONE:   if (start) state_d = ST_SEARCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // busy/done follow the state register one edge later so every output is a flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q  <= '0;
            k_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            form     <= IMM_FORM_DIRECT;
            shift_op <= '0;
        end else begin
            busy <= (state_q == ST_SEARCH);
            done <= (state_q == ST_DONE);
            if (accept) begin
                value_q <= value;
                k_q     <= '0;
            end else if (state_q == ST_SEARCH && !last) begin
                k_q <= k_q + 6'd1;
            end
            if (state_q == ST_SEARCH) begin
                if (fits) begin
                    found    <= 1'b1;
                    form     <= k_q[5:4];
                    shift_op <= {k_q[3:0], imm8};
                end else if (last) begin
                    found    <= 1'b0;
                    form     <= IMM_FORM_DIRECT;
                    shift_op <= '0;
                end
            end
        end
    end

endmodule

// File: doc/imm_operand_encoder.md
# imm_operand_encoder

Multi-cycle encoder that converts a 32-bit constant into the ARM data-processing immediate shifter operand `{rotate_imm[3:0], imm8[7:0]}`. The EXE-stage operand generator decodes that field as `ror(zero_extend(imm8), 2*rotate_imm)`; this block is its inverse. It is used by the instruction-memory loader and the self-test sequencer to build immediate instructions at run time. When the constant itself cannot be encoded, the block also searches its bitwise-inverted form (MOV↔MVN, AND↔BIC) and its negated form (ADD↔SUB, CMP↔CMN).

## Interface
- `WORD`, 32: operand width.
- `SHIFTER_OPERAND`, 12: encoded field width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `value` input 32: constant to encode; captured on the accepted `start` edge.
- `busy` output 1: high in SEARCH.
- `done` output 1: high in DONE; results are valid while high.
- `found` output 1: an encoding exists.
- `form` output 2: `00` direct, `01` inverted (`~value`), `10` negated (`-value`, two's complement), `11` unused.
- `shift_op` output 12: `{rot, imm8}`.

## Operation
- FSM states: IDLE, SEARCH, DONE.
  - IDLE to SEARCH on `start`.
  - SEARCH to DONE on a match, or after the last candidate.
  - DONE to SEARCH on `start`. Otherwise DONE holds.
- On accept, capture `value` and set candidate index k = 0.
- Candidate k: form = k/16, rot = k%16. Order is all 16 rotations of direct, then inverted, then negated. 48 candidates total.
- Candidate operand c:
  - form 0: c = value.
  - form 1: c = ~value.
  - form 2: c = 32-bit `-value`, wrap-around (`-0x80000000` = `0x80000000`).
- Test: t = rol(c, 2*rot). The candidate matches iff t[31:8] == 0, with imm8 = t[7:0].
- Exactly one candidate is tested per SEARCH cycle. The first match wins, so the smallest form is preferred, then the smallest rot.
- On a match: register `found`=1, `form`, and `shift_op`={rot, imm8}.
- On exhaustion with no match: `found`=0, `form`=00, `shift_op`=0.
- `start` in SEARCH is ignored. No abort; `value` changes during SEARCH have no effect.
- `start` in DONE restarts the search with the new `value`. `done` drops the next cycle.
- Value 0 matches at k=0 with `shift_op`=0x000.

## Timing
- Reset values: `busy`=0, `done`=0, `found`=0, `form`=00, `shift_op`=0. State = IDLE, k = 0.
- Reset asserted mid-search aborts immediately. After release the block is in IDLE with reset outputs.
- `start` sampled at edge 0. Candidate k is tested during cycle k+1. On a match at k, `done`=1 from edge k+2.
- Minimum latency is 2 cycles. No match gives `done` at edge 49.
- `busy` is high from edge 1 until the edge where `done` rises. `busy` and `done` are never high together.
- Outputs are registered only, with no combinational path from inputs to outputs.

## Structure
- Shared defines file, next to the existing `WORD`/`SHIFTER_OPERAND` defines:
  - `IMM_FORM_DIRECT`, `IMM_FORM_INV`, `IMM_FORM_NEG`.
  - `IMM_CANDIDATES` = 48.
  - State encodings.
- Sub-module `imm_fit_check` (combinational): inputs `c[31:0]`, `rot[3:0]`; outputs `fits`, `imm8[7:0]`.
- The top level holds the FSM, the 6-bit candidate counter, the form mux, and the result registers.

## Test plan
- `0x000000FF` → `found`=1, `form`=00, `shift_op`=0x0FF, `done` at edge 2.
- `0xFF000000` → `form`=00, `shift_op`=0x4FF (k=4), `done` at edge 6.
- `0xFFFFFF00` → `form`=01, `shift_op`=0x0FF (k=16), `done` at edge 18.
- `0xFFFFFE00` → `form`=10, `shift_op`=0xC02 (k=44), `done` at edge 46.
- `0x00000101` → `found`=0, `shift_op`=0, `done` at edge 49. `busy` high on edges 1–48.
- Control cases:
  - Pulse `start` with `0x12` during SEARCH → ignored.
  - Assert `rst` low at edge 10 of a search → all outputs 0 immediately; after release, `start` with `0x3F0` → `shift_op`=0xE3F at edge 16 (k=14).
